complex_mult_sequencer: RTL and testbench

Time-multiplexes one shared 16-bit Q1.15 fixed-point multiplier to compute a full complex product. It issues four real products back-to-back, collects them in order, and combines them into saturated real and imaginary parts. It sits between the FFT butterfly/twiddle stage and the single multiplier instance, so the spectral datapath needs one DSP multiplier instead of four.

---
 rtl/complex_mult_sequencer_pkg.sv | 22 ++
 rtl/complex_mult_sequencer_sat_addsub.sv | 35 +++
 rtl/complex_mult_sequencer.sv | 161 ++++++++++++++++
 tb/tb_complex_mult_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/complex_mult_sequencer_pkg.sv
// Shared definitions for the complex multiply sequencer: FSM encoding,
// default data width, Q1.15 saturation limits and product slot indices.
package complex_mult_sequencer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int SAT_MAX    = 32767;
    localparam int SAT_MIN    = -32768;

    // Product slots, also the issue order on the shared multiplier
    localparam logic [1:0] P0 = 2'd0;   // a_re * b_re
    localparam logic [1:0] P1 = 2'd1;   // a_im * b_im
    localparam logic [1:0] P2 = 2'd2;   // a_re * b_im
    localparam logic [1:0] P3 = 2'd3;   // a_im * b_re

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        COMBINE = 2'd3
    } state_t;

endpackage

// File: rtl/complex_mult_sequencer_sat_addsub.sv
// Combinational add/subtract of two signed operands, formed one bit wider
// and clamped back to the operand width.
module sat_addsub
    import complex_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] MAX_V = SAT_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_V = SAT_MIN[WIDTH-1:0];

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        if (sub) begin
            sum = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        end else begin
            sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        end
        // The two top bits disagree only when the result left the WIDTH range
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            y = sum[WIDTH] ? MIN_V : MAX_V;
        end else begin
            y = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/complex_mult_sequencer.sv
// Computes a*b or a*conj(b) in Q1.15 by issuing four real products to one
// shared 2-cycle multiplier, collecting them and combining with saturation.
module complex_mult_sequencer
    import complex_mult_sequencer_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    conj_b,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic signed [WIDTH-1:0] p_re,
    output logic signed [WIDTH-1:0] p_im,
    output logic                    mul_enable,
    output logic signed [WIDTH-1:0] mul_a,
    output logic signed [WIDTH-1:0] mul_b,
    input  logic signed [WIDTH-1:0] mul_product,
    input  logic                    mul_done
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t state_reg, state_next;

    logic [1:0]              k_reg;
    logic [1:0]              rcv_reg;
    logic                    full_reg;
    logic [TW-1:0]           tmo_reg;
    logic                    conj_reg;
    logic signed [WIDTH-1:0] a_re_reg, a_im_reg, b_re_reg, b_im_reg;
    logic signed [WIDTH-1:0] slot_reg [4];
    logic signed [WIDTH-1:0] p_re_reg, p_im_reg;
    logic                    done_reg, err_reg;

    logic                    capture_en;
    logic                    all_rcvd;
    logic                    timeout_hit;
    logic signed [WIDTH-1:0] re_sum, im_sum;
    logic signed [WIDTH-1:0] im_a, im_b;

    assign capture_en  = mul_done && !full_reg &&
                         (state_reg == ISSUE || state_reg == WAIT);
    // Counting the return arriving this cycle lets COMBINE follow the last capture directly
    assign all_rcvd    = full_reg || (capture_en && rcv_reg == P3);
    assign timeout_hit = (state_reg == WAIT) && !all_rcvd && (tmo_reg == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (k_reg == P3) state_next = WAIT;
            WAIT: begin
                if (all_rcvd) begin
                    state_next = COMBINE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            COMBINE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_reg == ISSUE) begin
            case (k_reg)
                P0:      begin mul_a = a_re_reg; mul_b = b_re_reg; end
                P1:      begin mul_a = a_im_reg; mul_b = b_im_reg; end
                P2:      begin mul_a = a_re_reg; mul_b = b_im_reg; end
                default: begin mul_a = a_im_reg; mul_b = b_re_reg; end
            endcase
        end
    end

    // conj(b) flips the sign of b_im: re gains +P1, im becomes P3 - P2
    assign im_a = conj_reg ? slot_reg[P3] : slot_reg[P2];
    assign im_b = conj_reg ? slot_reg[P2] : slot_reg[P3];

    sat_addsub #(.WIDTH(WIDTH)) u_sat_re (
        .a   (slot_reg[P0]),
        .b   (slot_reg[P1]),
        .sub (!conj_reg),
        .y   (re_sum)
    );

    sat_addsub #(.WIDTH(WIDTH)) u_sat_im (
        .a   (im_a),
        .b   (im_b),
        .sub (conj_reg),
        .y   (im_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            rcv_reg   <= '0;
            full_reg  <= 1'b0;
            tmo_reg   <= '0;
            conj_reg  <= 1'b0;
            a_re_reg  <= '0;
            a_im_reg  <= '0;
            b_re_reg  <= '0;
            b_im_reg  <= '0;
            for (int i = 0; i < 4; i++) slot_reg[i] <= '0;
            p_re_reg  <= '0;
            p_im_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == COMBINE);
            err_reg   <= timeout_hit;

            if (state_reg == IDLE && start) begin
                conj_reg <= conj_b;
                a_re_reg <= a_re;
                a_im_reg <= a_im;
                b_re_reg <= b_re;
                b_im_reg <= b_im;
                k_reg    <= '0;
                rcv_reg  <= '0;
                full_reg <= 1'b0;
            end

            if (state_reg == ISSUE) k_reg <= k_reg + 2'd1;

            if (capture_en) begin
                slot_reg[rcv_reg] <= mul_product;
                rcv_reg           <= rcv_reg + 2'd1;
                if (rcv_reg == P3) full_reg <= 1'b1;
            end

            tmo_reg <= (state_reg == WAIT) ? tmo_reg + TW'(1) : '0;

            if (state_reg == COMBINE) begin
                p_re_reg <= re_sum;
                p_im_reg <= im_sum;
            end
        end
    end

    assign busy       = (state_reg != IDLE);
    assign mul_enable = (state_reg == ISSUE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign p_re       = p_re_reg;
    assign p_im       = p_im_reg;

endmodule

// File: tb/tb_complex_mult_sequencer.sv
// Directed bench for complex_mult_sequencer with a 2-cycle Q1.15 multiplier
// model that can withhold returns to provoke a timeout.
module tb_complex_mult_sequencer;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                conj_b = 1'b0;
    logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic                busy, done, err;
    logic signed [W-1:0] p_re, p_im;
    logic                mul_enable;
    logic signed [W-1:0] mul_a, mul_b;
    logic signed [W-1:0] mul_product;
    logic                mul_done;

    int n_cmp = 0;
    int n_bad = 0;

    complex_mult_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .conj_b      (conj_b),
        .a_re        (a_re),
        .a_im        (a_im),
        .b_re        (b_re),
        .b_im        (b_im),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .p_re        (p_re),
        .p_im        (p_im),
        .mul_enable  (mul_enable),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: Q1.15 product truncated toward zero, 2-cycle latency
    function automatic logic signed [W-1:0] q15(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
        int p;
        p = (int'(x) * int'(y)) / 32768;
        return W'(p);
    endfunction

    logic                v1 = 1'b0, v2 = 1'b0;
    logic signed [W-1:0] r1 = '0, r2 = '0;
    int                  ret_cnt = 0;
    int                  ret_stop = 1 << 30;

    always @(posedge clk) begin
        v1 <= mul_enable;
        r1 <= q15(mul_a, mul_b);
        v2 <= v1;
        r2 <= r1;
        if (mul_done) ret_cnt <= ret_cnt + 1;
    end

    assign mul_done    = v2 && (ret_cnt < ret_stop);
    assign mul_product = r2;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation starting in the current cycle (N) and checks N+1..N+8
    task automatic run_op(input string name, input int ar, input int ai,
                          input int br, input int bi, input logic cj,
                          input int exp_re, input int exp_im);
        int ea[4];
        int eb[4];
        ea = '{ar, ai, ar, ai};
        eb = '{br, bi, bi, br};
        a_re = W'(ar); a_im = W'(ai); b_re = W'(br); b_im = W'(bi);
        conj_b = cj;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_val($sformatf("%s mul_enable c%0d", name, c), 32'(mul_enable), 32'(c <= 4));
            if (c <= 4) begin
                check_val($sformatf("%s mul_a k%0d", name, c - 1), 32'($signed(mul_a)), ea[c-1]);
                check_val($sformatf("%s mul_b k%0d", name, c - 1), 32'($signed(mul_b)), eb[c-1]);
            end
            check_val($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c < 8));
            check_val($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == 8));
            check_val($sformatf("%s err c%0d", name, c), 32'(err), 32'd0);
            if (c == 8) begin
                check_val($sformatf("%s p_re", name), 32'($signed(p_re)), exp_re);
                check_val($sformatf("%s p_im", name), 32'($signed(p_im)), exp_im);
            end else begin
                tick();
            end
        end
        $display("op %-10s a=(%0d,%0d) b=(%0d,%0d) conj=%0d -> (%0d,%0d) expected (%0d,%0d)",
                 name, ar, ai, br, bi, cj, p_re, p_im, exp_re, exp_im);
    endtask

    initial begin
        tick();
        tick();
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset err", 32'(err), 32'd0);
        check_val("reset mul_enable", 32'(mul_enable), 32'd0);
        check_val("reset mul_a", 32'($signed(mul_a)), 32'd0);
        check_val("reset mul_b", 32'($signed(mul_b)), 32'd0);
        check_val("reset p_re", 32'($signed(p_re)), 32'd0);
        check_val("reset p_im", 32'($signed(p_im)), 32'd0);
        reset = 1'b0;
        tick();

        // (0.5+0.5j)^2 = j*0.5 ; with conj = 0.5
        run_op("basic", 16384, 16384, 16384, 16384, 1'b0, 0, 16384);
        run_op("conj", 16384, 16384, 16384, 16384, 1'b1, 16384, 0);
        run_op("sat_pos", 32767, 32767, 32767, -32767, 1'b0, 32767, 0);
        run_op("sat_neg", -32768, 32767, 32767, 32767, 1'b0, -32768, -1);

        // start held high through two operations: second accepted at N+8 only
        a_re = 16'sd8192; a_im = -16'sd16384; b_re = 16'sd16384; b_im = 16'sd8192;
        conj_b = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check_val($sformatf("b2b mul_enable c%0d", c), 32'(mul_enable),
                      32'((c >= 1 && c <= 4) || (c >= 9 && c <= 12)));
            check_val($sformatf("b2b busy c%0d", c), 32'(busy), 32'(c != 8 && c != 16));
            check_val($sformatf("b2b done c%0d", c), 32'(done), 32'(c == 8 || c == 16));
            if (c == 8 || c == 16) begin
                check_val($sformatf("b2b p_re c%0d", c), 32'($signed(p_re)), 8192);
                check_val($sformatf("b2b p_im c%0d", c), 32'($signed(p_im)), -6144);
                $display("op b2b%-7d a=(8192,-16384) b=(16384,8192) conj=0 -> (%0d,%0d) expected (8192,-6144)",
                         c, p_re, p_im);
            end
        end
        start = 1'b0;
        tick();

        // Only two products return: err at N+13, results keep previous values
        ret_stop = ret_cnt + 2;
        a_re = 16'sd16384; a_im = 16'sd16384; b_re = 16'sd16384; b_im = 16'sd16384;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            check_val($sformatf("tmo err c%0d", c), 32'(err), 32'(c == 13));
            check_val($sformatf("tmo done c%0d", c), 32'(done), 32'd0);
            check_val($sformatf("tmo busy c%0d", c), 32'(busy), 32'(c < 13));
            if (c < 13) tick();
        end
        check_val("tmo p_re held", 32'($signed(p_re)), 8192);
        check_val("tmo p_im held", 32'($signed(p_im)), -6144);
        $display("op timeout   err=%0d p=(%0d,%0d) expected err=1 p=(8192,-6144)", err, p_re, p_im);
        tick();
        check_val("tmo err pulse ends", 32'(err), 32'd0);
        ret_stop = 1 << 30;
        tick();

        // Reset during the third issue cycle abandons the operation
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("rst pre mul_enable", 32'(mul_enable), 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst mul_enable", 32'(mul_enable), 32'd0);
        check_val("rst p_re", 32'($signed(p_re)), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_val($sformatf("rst quiet done c%0d", c), 32'(done), 32'd0);
            check_val($sformatf("rst quiet err c%0d", c), 32'(err), 32'd0);
            tick();
        end
        $display("op reset     busy=%0d done=%0d err=%0d after mid-operation reset", busy, done, err);
        run_op("post_rst", 8192, -16384, 16384, 8192, 1'b1, 0, -10240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
